score_display_ctrl: RTL and testbench

//  Owns the BCD game score and drives the per-digit glyph-renderer (score_rom) instances.
//  - Accumulates point events into a saturating BCD score.
//  - From VGA hcount/vcount, generates each digit's score_val, h_enable and v_enable windows.
//  - Merges the renderers' returned pixel bits into one score_pixel for the VGA colour mux.

---
 rtl/score_pkg.sv | 17 +
 rtl/score_bcd_digit.sv | 40 ++++
 rtl/score_display_ctrl.sv | 177 +++++++++++++++++
 tb/tb_score_display_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the score display: accumulator states,
// BCD limits and digit-slot placement.
package score_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CARRY = 1'b1
    } acc_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Left pixel column of a digit slot; slot 0 is the leftmost (MSD) position.
    function automatic int slot_x(input int slot, input int x0, input int glyph_w, input int gap);
        return x0 + slot * (glyph_w + gap);
    endfunction

endpackage

// File: rtl/score_bcd_digit.sv
// One BCD digit register. Add and increment share one adder; carry is
// combinational so the accumulator FSM can decide its next step in the same clock.
module score_bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       set9,
    input  logic       add_en,
    input  logic       inc,
    input  logic [3:0] add_val,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] operand;
    logic [4:0] sum;
    logic [4:0] wrapped;

    always_comb begin
        operand = add_en ? add_val : {3'b000, inc};
        sum     = {1'b0, digit} + {1'b0, operand};
        wrapped = sum - 5'd10;
        carry   = (sum > 5'd9);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit <= 4'd0;
        end else if (clear) begin
            digit <= 4'd0;
        end else if (set9) begin
            digit <= BCD_NINE;
        end else if (add_en || inc) begin
            digit <= carry ? wrapped[3:0] : sum[3:0];
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Saturating BCD score accumulator with a frame-synchronous shadow copy,
// per-digit glyph windows for the score_rom renderers and a merged pixel output.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int X0        = 16,
    parameter int Y0        = 8,
    parameter int GLYPH_W   = 16,
    parameter int GLYPH_H   = 16,
    parameter int GAP       = 4,
    parameter int V_VISIBLE = 480,
    parameter int LZ_BLANK  = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  add_pts,
    input  logic [3:0]            pts_val,
    input  logic                  clear_score,
    input  logic [DIGITS-1:0]     pixel_in,
    output logic                  busy,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   score_val,
    output logic [DIGITS-1:0]     h_enable,
    output logic                  v_enable,
    output logic                  score_pixel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [9:0] Y_LO   = 10'(Y0);
    localparam logic [9:0] Y_HI   = 10'(Y0 + GLYPH_H);
    localparam logic [9:0] V_LINE = 10'(V_VISIBLE);

    acc_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        digit_q [DIGITS];
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] add_en;
    logic              accept;
    logic              set9;

    logic              pending;
    logic              frame_end;
    logic              v_row;
    logic [DIGITS-1:0] h_hit;
    logic [DIGITS-1:0] lit;
    logic              nz_seen;
    logic [DIGITS-1:0] h_enable_d1;

    // Only digit 0 takes new points; higher digits only ever see the rippling carry.
    always_comb begin
        accept = add_pts && (pts_val <= BCD_NINE) && (state == IDLE) && !clear_score;
        set9   = (state == CARRY) && carry[idx] && (idx == LAST_IDX) && !clear_score;
        for (int i = 0; i < DIGITS; i++) begin
            inc[i]    = (state == CARRY) && (idx == IDX_W'(i)) && !clear_score;
            add_en[i] = (i == 0) && accept;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        score_bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear_score),
            .set9    (set9),
            .add_en  (add_en[g]),
            .inc     (inc[g]),
            .add_val (pts_val),
            .digit   (digit_q[g]),
            .carry   (carry[g])
        );
    end

    always_comb begin
        score = '0;
        for (int i = 0; i < DIGITS; i++) begin
            score[4*i +: 4] = digit_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear_score) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && carry[0]) begin
                        state <= CARRY;
                        idx   <= IDX_W'(1);
                        busy  <= 1'b1;
                    end
                end
                CARRY: begin
                    if (carry[idx] && (idx != LAST_IDX)) begin
                        idx <= idx + 1'b1;
                    end else begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        if (carry[idx]) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The frame-end trigger counts as pending in its own clock, so an idle
    // accumulator updates the shadow one clock after line V_VISIBLE begins.
    assign frame_end = (hcount == 10'd0) && (vcount == V_LINE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending   <= 1'b0;
            score_val <= '0;
        end else if ((pending || frame_end) && (state == IDLE)) begin
            pending   <= 1'b0;
            score_val <= score;
        end else if (frame_end) begin
            pending   <= 1'b1;
        end
    end

    assign v_row = (vcount >= Y_LO) && (vcount < Y_HI);

    for (genvar g = 0; g < DIGITS; g++) begin : g_window
        localparam int SLOT = DIGITS - 1 - g;
        localparam logic [9:0] H_LO = 10'(slot_x(SLOT, X0, GLYPH_W, GAP));
        localparam logic [9:0] H_HI = 10'(slot_x(SLOT, X0, GLYPH_W, GAP) + GLYPH_W);
        assign h_hit[g] = (hcount >= H_LO) && (hcount < H_HI);
    end

    // Walk from the MSD down: a digit is lit once any digit at or above it is non-zero.
    always_comb begin
        nz_seen = 1'b0;
        lit     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen = nz_seen || (score_val[4*i +: 4] != 4'd0);
            lit[i]  = nz_seen || (i == 0) || (LZ_BLANK == 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_enable    <= 1'b0;
            h_enable    <= '0;
            h_enable_d1 <= '0;
            score_pixel <= 1'b0;
        end else begin
            v_enable    <= v_row;
            h_enable    <= h_hit & lit & {DIGITS{v_row}};
            h_enable_d1 <= h_enable;
            score_pixel <= |(pixel_in & h_enable_d1);
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: accumulation, carry ripple, saturation,
// shadow timing, glyph windows with leading-zero blanking and pixel merge.
module tb_score_display_ctrl;

    logic        clk;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        add_pts;
    logic [3:0]  pts_val;
    logic        clear_score;
    logic [3:0]  pixel_in;
    logic        busy;
    logic        overflow;
    logic [15:0] score;
    logic [15:0] score_val;
    logic [3:0]  h_enable;
    logic        v_enable;
    logic        score_pixel;

    int total = 0;
    int bad   = 0;

    score_display_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .add_pts     (add_pts),
        .pts_val     (pts_val),
        .clear_score (clear_score),
        .pixel_in    (pixel_in),
        .busy        (busy),
        .overflow    (overflow),
        .score       (score),
        .score_val   (score_val),
        .h_enable    (h_enable),
        .v_enable    (v_enable),
        .score_pixel (score_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            check_output("busy_timeout", {15'd0, busy}, 16'd0);
        end
    endtask

    task automatic add(input logic [3:0] val);
        add_pts = 1'b1;
        pts_val = val;
        tick();
        add_pts = 1'b0;
        wait_idle();
    endtask

    function automatic logic [3:0] pix_pattern(input int h);
        return 4'b1100 | ((h % 2) == 1 ? 4'b0010 : 4'b0001);
    endfunction

    initial begin
        logic [3:0] hist [120];
        logic [3:0] exp_h;
        int         on_count;

        reset       = 1'b0;
        hcount      = 10'd300;
        vcount      = 10'd200;
        add_pts     = 1'b0;
        pts_val     = 4'd0;
        clear_score = 1'b0;
        pixel_in    = 4'b0000;

        tick();
        tick();
        check_output("rst_score", score, 16'h0000);
        check_output("rst_busy", {15'd0, busy}, 16'd0);
        check_output("rst_overflow", {15'd0, overflow}, 16'd0);
        check_output("rst_h_enable", {12'd0, h_enable}, 16'd0);
        check_output("rst_pixel", {15'd0, score_pixel}, 16'd0);
        check_output("rst_score_val", score_val, 16'h0000);
        reset = 1'b1;
        tick();

        add_pts = 1'b1;
        pts_val = 4'd7;
        tick();
        add_pts = 1'b0;
        check_output("add7_score", score, 16'h0007);
        check_output("add7_busy", {15'd0, busy}, 16'd0);
        tick();
        check_output("add7_busy_later", {15'd0, busy}, 16'd0);

        add_pts = 1'b1;
        pts_val = 4'd12;
        tick();
        add_pts = 1'b0;
        check_output("invalid_pts", score, 16'h0007);

        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        for (int k = 0; k < 111; k++) add(4'd9);
        check_output("build_0999", score, 16'h0999);

        add_pts = 1'b1;
        pts_val = 4'd1;
        tick();
        check_output("ripple_busy1", {15'd0, busy}, 16'd1);
        check_output("ripple_mid", score, 16'h0990);
        pts_val = 4'd5;
        tick();
        add_pts = 1'b0;
        check_output("ripple_busy2", {15'd0, busy}, 16'd1);
        tick();
        check_output("ripple_busy3", {15'd0, busy}, 16'd1);
        tick();
        check_output("ripple_done_busy", {15'd0, busy}, 16'd0);
        check_output("ripple_score", score, 16'h1000);

        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        for (int k = 0; k < 1110; k++) add(4'd9);
        add(4'd5);
        check_output("build_9995", score, 16'h9995);
        add(4'd9);
        check_output("sat_score", score, 16'h9999);
        check_output("sat_overflow", {15'd0, overflow}, 16'd1);
        add(4'd1);
        check_output("sat_again", score, 16'h9999);
        check_output("sat_sticky", {15'd0, overflow}, 16'd1);

        clear_score = 1'b1;
        add_pts     = 1'b1;
        pts_val     = 4'd3;
        tick();
        clear_score = 1'b0;
        add_pts     = 1'b0;
        check_output("clear_score", score, 16'h0000);
        check_output("clear_overflow", {15'd0, overflow}, 16'd0);
        check_output("clear_busy", {15'd0, busy}, 16'd0);

        vcount = 10'd100;
        for (int k = 0; k < 4; k++) add(4'd9);
        add(4'd6);
        check_output("build_0042", score, 16'h0042);
        check_output("shadow_hold", score_val, 16'h0000);
        hcount = 10'd5;
        vcount = 10'd480;
        tick();
        check_output("shadow_not_h0", score_val, 16'h0000);
        hcount = 10'd0;
        tick();
        check_output("shadow_latch", score_val, 16'h0042);
        vcount = 10'd481;
        tick();

        vcount   = 10'd8;
        hcount   = 10'd0;
        on_count = 0;
        tick();
        for (int h = 0; h < 120; h++) begin
            hcount   = 10'(h);
            pixel_in = pix_pattern(h);
            tick();
            exp_h = 4'b0000;
            if (h >= 56 && h < 72) exp_h[1] = 1'b1;
            if (h >= 76 && h < 92) exp_h[0] = 1'b1;
            hist[h] = exp_h;
            check_output("h_enable_sweep", {12'd0, h_enable}, {12'd0, exp_h});
            if (h_enable[1] === 1'b1) on_count++;
            if (h >= 2) begin
                check_output("pixel_merge", {15'd0, score_pixel}, {15'd0, |(pix_pattern(h) & hist[h-2])});
            end
        end
        check_output("h1_pulse_len", 16'(on_count), 16'd16);
        check_output("v_enable_row", {15'd0, v_enable}, 16'd1);

        vcount = 10'd23;
        hcount = 10'd60;
        tick();
        check_output("last_row_h", {12'd0, h_enable}, 16'h0002);
        check_output("last_row_v", {15'd0, v_enable}, 16'd1);
        vcount = 10'd24;
        tick();
        check_output("below_row_h", {12'd0, h_enable}, 16'h0000);
        check_output("below_row_v", {15'd0, v_enable}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
